// File: rtl/axi_apb_pkg.sv
// Shared definitions for the APB <-> AXI-Lite bridges: bridge FSM encoding and
// AXI response codes.
package axi_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DONE    = 3'd5
    } bridge_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/apb_to_axi_lite_bridge.sv
// APB4 completer to AXI4-Lite manager bridge: each APB transfer becomes one
// AXI-Lite write or read, with PREADY held low until the AXI response returns.
module apb_to_axi_lite_bridge
    import axi_apb_pkg::*;
#(
    parameter int unsigned  ADDR_WIDTH = 32,
    parameter int unsigned  DATA_WIDTH = 32,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [STRB_WIDTH-1:0] PSTRB,
    input  logic [2:0]            PPROT,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [2:0]            AWPROT,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [STRB_WIDTH-1:0] WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [2:0]            ARPROT,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY
);

    bridge_state_e           state_q, state_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   strb_q;
    logic [2:0]              prot_q;
    logic                    write_q;

    logic                    setup;
    logic                    aw_fire;
    logic                    w_fire;

    assign setup   = PSEL && !PENABLE;
    assign aw_fire = !aw_done_q && AWREADY;
    assign w_fire  = !w_done_q && WREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
        end
    end

    // Request fields are captured only on the setup cycle taken in IDLE.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            write_q <= 1'b0;
        end else if (state_q == ST_IDLE && setup) begin
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            prot_q  <= PPROT;
            write_q <= PWRITE;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        prdata_d  = prdata_q;
        AWVALID   = 1'b0;
        WVALID    = 1'b0;
        BREADY    = 1'b0;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = PWRITE ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                AWVALID = !aw_done_q;
                WVALID  = !w_done_q;
                if (aw_fire) aw_done_d = 1'b1;
                if (w_fire)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    err_d   = (BRESP == RESP_SLVERR) || (BRESP == RESP_DECERR);
                    state_d = ST_DONE;
                end
            end
            ST_RD_REQ: begin
                ARVALID = 1'b1;
                if (ARREADY) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                RREADY = 1'b1;
                if (RVALID) begin
                    if (!write_q) prdata_d = RDATA;
                    err_d   = (RRESP == RESP_SLVERR) || (RRESP == RESP_DECERR);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                PREADY  = 1'b1;
                PSLVERR = err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign PRDATA = prdata_q;
    assign AWADDR = addr_q;
    assign ARADDR = addr_q;
    assign AWPROT = prot_q;
    assign ARPROT = prot_q;
    assign WDATA  = wdata_q;
    assign WSTRB  = strb_q;

endmodule

// File: tb/tb_apb_to_axi_lite_bridge.sv
// Directed bench for apb_to_axi_lite_bridge with a delay-configurable AXI-Lite
// slave model and protocol monitors.
module tb_apb_to_axi_lite_bridge;
    import axi_apb_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic [3:0]  PSTRB = '0;
    logic [2:0]  PPROT = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    int checks = 0;
    int failures = 0;

    always #5 ACLK = ~ACLK;

    apb_to_axi_lite_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    // Slave model configuration
    int unsigned aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
    logic [31:0] rdata_cfg = '0;

    int unsigned aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic        aw_got, w_got, b_pend, r_pend;
    logic        awv_prev, awr_prev, wv_prev, wr_prev, arv_prev, arr_prev;
    int          aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_vcyc, w_vcyc, viol;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    logic [2:0]  cap_awprot, cap_arprot;

    assign AWREADY = AWVALID && (aw_wait == aw_delay);
    assign WREADY  = WVALID && (w_wait == w_delay);
    assign ARREADY = ARVALID && (ar_wait == ar_delay);
    assign BVALID  = b_pend && (b_wait == b_delay);
    assign BRESP   = BVALID ? bresp_cfg : 2'b00;
    assign RVALID  = r_pend && (r_wait == r_delay);
    assign RRESP   = RVALID ? rresp_cfg : 2'b00;
    assign RDATA   = RVALID ? rdata_cfg : 32'h0;

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            awv_prev <= 1'b0; awr_prev <= 1'b0; wv_prev <= 1'b0; wr_prev <= 1'b0;
            arv_prev <= 1'b0; arr_prev <= 1'b0;
            aw_hs <= 0; w_hs <= 0; b_hs <= 0; ar_hs <= 0; r_hs <= 0;
            aw_vcyc <= 0; w_vcyc <= 0; viol <= 0;
            cap_awaddr <= '0; cap_wdata <= '0; cap_araddr <= '0;
            cap_wstrb <= '0; cap_awprot <= '0; cap_arprot <= '0;
        end else begin
            aw_wait <= (AWVALID && !AWREADY) ? aw_wait + 1 : 0;
            w_wait  <= (WVALID && !WREADY) ? w_wait + 1 : 0;
            ar_wait <= (ARVALID && !ARREADY) ? ar_wait + 1 : 0;
            b_wait  <= (b_pend && !BVALID) ? b_wait + 1 : 0;
            r_wait  <= (r_pend && !RVALID) ? r_wait + 1 : 0;
            aw_vcyc <= aw_vcyc + (AWVALID ? 1 : 0);
            w_vcyc  <= w_vcyc + (WVALID ? 1 : 0);
            if (AWVALID && AWREADY) begin
                aw_hs <= aw_hs + 1; cap_awaddr <= AWADDR; cap_awprot <= AWPROT;
            end
            if (WVALID && WREADY) begin
                w_hs <= w_hs + 1; cap_wdata <= WDATA; cap_wstrb <= WSTRB;
            end
            if ((aw_got || (AWVALID && AWREADY)) && (w_got || (WVALID && WREADY))) begin
                b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (AWVALID && AWREADY) aw_got <= 1'b1;
                if (WVALID && WREADY) w_got <= 1'b1;
            end
            if (BVALID && BREADY) begin b_pend <= 1'b0; b_hs <= b_hs + 1; end
            if (ARVALID && ARREADY) begin
                ar_hs <= ar_hs + 1; cap_araddr <= ARADDR; cap_arprot <= ARPROT; r_pend <= 1'b1;
            end
            if (RVALID && RREADY) begin r_pend <= 1'b0; r_hs <= r_hs + 1; end
            // Protocol monitors: withdrawn VALID, overlapping transactions, stray PSLVERR
            awv_prev <= AWVALID; awr_prev <= AWREADY;
            wv_prev <= WVALID; wr_prev <= WREADY;
            arv_prev <= ARVALID; arr_prev <= ARREADY;
            if ((awv_prev && !awr_prev && !AWVALID) || (wv_prev && !wr_prev && !WVALID) ||
                (arv_prev && !arr_prev && !ARVALID)) viol <= viol + 1;
            if (ARVALID && (b_pend || aw_got || w_got || AWVALID || WVALID)) viol <= viol + 1;
            if ((AWVALID || WVALID) && r_pend) viol <= viol + 1;
            if (PSLVERR && !PREADY) viol <= viol + 1;
        end
    end

    // One APB transfer; returns the cycle index (setup = 0) at which PREADY was seen.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [2:0] prot,
                            output int unsigned ncyc, output logic [31:0] rd,
                            output logic err, output logic tmo);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
        PWDATA = data; PSTRB = strb; PPROT = prot;
        @(posedge ACLK); #1;
        PENABLE = 1'b1;
        PADDR = ~addr; PWDATA = ~data; PSTRB = ~strb; PPROT = ~prot;
        ncyc = 1; tmo = 1'b0;
        while (PREADY !== 1'b1) begin
            if (ncyc >= 60) begin tmo = 1'b1; break; end
            @(posedge ACLK); #1;
            ncyc++;
        end
        rd = PRDATA; err = PSLVERR;
        @(posedge ACLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    int unsigned n;
    logic [31:0] rd;
    logic        err, tmo;
    int          s_aw, s_w, s_b, s_ar, s_r, s_awc, s_wc;

    task automatic snap();
        s_aw = aw_hs; s_w = w_hs; s_b = b_hs; s_ar = ar_hs; s_r = r_hs;
        s_awc = aw_vcyc; s_wc = w_vcyc;
    endtask

    task automatic test_reset();
        checks++;
        if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, PREADY, PSLVERR} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b want=0", {AWVALID, WVALID, ARVALID, BREADY, RREADY, PREADY, PSLVERR});
        end
        checks++;
        if (PRDATA !== 32'h0 || AWADDR !== 32'h0 || WDATA !== 32'h0 || WSTRB !== 4'h0) begin
            failures++; $display("FAIL reset_data prdata=%h awaddr=%h wdata=%h wstrb=%h want=0", PRDATA, AWADDR, WDATA, WSTRB);
        end
    endtask

    task automatic test_write_basic();
        snap();
        apb_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b011, n, rd, err, tmo);
        checks++; if (tmo) begin failures++; $display("FAIL wr_basic_timeout got=1 want=0"); end
        checks++; if (n != 3) begin failures++; $display("FAIL wr_basic_latency got=%0d want=3", n); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL wr_basic_slverr got=%b want=0", err); end
        checks++;
        if (aw_hs - s_aw != 1 || w_hs - s_w != 1 || b_hs - s_b != 1) begin
            failures++; $display("FAIL wr_basic_hs aw=%0d w=%0d b=%0d want=1/1/1", aw_hs - s_aw, w_hs - s_w, b_hs - s_b);
        end
        checks++;
        if (cap_awaddr !== 32'h10 || cap_wdata !== 32'hDEAD_BEEF || cap_wstrb !== 4'hF || cap_awprot !== 3'b011) begin
            failures++; $display("FAIL wr_basic_fields addr=%h data=%h strb=%h prot=%b want=10/deadbeef/f/011", cap_awaddr, cap_wdata, cap_wstrb, cap_awprot);
        end
    endtask

    task automatic test_read_delayed();
        snap();
        r_delay = 5; rdata_cfg = 32'h1234_5678;
        apb_xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'b001, n, rd, err, tmo);
        r_delay = 0;
        checks++; if (n != 8 || tmo) begin failures++; $display("FAIL rd_delay_latency got=%0d want=8", n); end
        checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL rd_delay_data got=%h want=12345678", rd); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rd_delay_slverr got=%b want=0", err); end
        checks++;
        if (cap_araddr !== 32'h20 || cap_arprot !== 3'b001 || ar_hs - s_ar != 1 || r_hs - s_r != 1) begin
            failures++; $display("FAIL rd_delay_ar addr=%h prot=%b ar=%0d r=%0d want=20/001/1/1", cap_araddr, cap_arprot, ar_hs - s_ar, r_hs - s_r);
        end
    endtask

    task automatic test_write_ordering();
        snap();
        aw_delay = 4;
        apb_xfer(1'b1, 32'h30, 32'h0000_0A0A, 4'h3, 3'b000, n, rd, err, tmo);
        aw_delay = 0;
        checks++; if (n != 7 || tmo) begin failures++; $display("FAIL ord_aw_latency got=%0d want=7", n); end
        checks++;
        if (aw_vcyc - s_awc != 5 || w_vcyc - s_wc != 1 || b_hs - s_b != 1) begin
            failures++; $display("FAIL ord_aw_valid awcyc=%0d wcyc=%0d b=%0d want=5/1/1", aw_vcyc - s_awc, w_vcyc - s_wc, b_hs - s_b);
        end
        checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL wr_keeps_prdata got=%h want=12345678", rd); end
        snap();
        w_delay = 4;
        apb_xfer(1'b1, 32'h34, 32'h0000_0B0B, 4'hC, 3'b000, n, rd, err, tmo);
        w_delay = 0;
        checks++; if (n != 7 || tmo) begin failures++; $display("FAIL ord_w_latency got=%0d want=7", n); end
        checks++;
        if (aw_vcyc - s_awc != 1 || w_vcyc - s_wc != 5 || b_hs - s_b != 1) begin
            failures++; $display("FAIL ord_w_valid awcyc=%0d wcyc=%0d b=%0d want=1/5/1", aw_vcyc - s_awc, w_vcyc - s_wc, b_hs - s_b);
        end
        checks++;
        if (cap_awaddr !== 32'h34 || cap_wdata !== 32'h0000_0B0B || cap_wstrb !== 4'hC) begin
            failures++; $display("FAIL ord_w_fields addr=%h data=%h strb=%h want=34/00000b0b/c", cap_awaddr, cap_wdata, cap_wstrb);
        end
    endtask

    task automatic test_errors();
        bresp_cfg = RESP_SLVERR;
        apb_xfer(1'b1, 32'h40, 32'h5, 4'h1, 3'b000, n, rd, err, tmo);
        bresp_cfg = RESP_OKAY;
        checks++; if (err !== 1'b1 || n != 3) begin failures++; $display("FAIL wr_slverr got=%b cyc=%0d want=1/3", err, n); end
        rresp_cfg = RESP_DECERR; rdata_cfg = 32'hCAFE_0001;
        apb_xfer(1'b0, 32'h44, 32'h0, 4'h0, 3'b000, n, rd, err, tmo);
        rresp_cfg = RESP_OKAY;
        checks++; if (err !== 1'b1 || n != 3) begin failures++; $display("FAIL rd_decerr got=%b cyc=%0d want=1/3", err, n); end
        checks++; if (rd !== 32'hCAFE_0001) begin failures++; $display("FAIL rd_err_data got=%h want=cafe0001", rd); end
        apb_xfer(1'b0, 32'h48, 32'h0, 4'h0, 3'b000, n, rd, err, tmo);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b want=0", err); end
    endtask

    task automatic test_back_to_back();
        snap();
        apb_xfer(1'b1, 32'h0, 32'h1111_1111, 4'hF, 3'b000, n, rd, err, tmo);
        checks++;
        if (n != 3 || cap_awaddr !== 32'h0 || cap_wdata !== 32'h1111_1111) begin
            failures++; $display("FAIL b2b_w0 cyc=%0d addr=%h data=%h want=3/0/11111111", n, cap_awaddr, cap_wdata);
        end
        rdata_cfg = 32'hAAAA_5555;
        apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, n, rd, err, tmo);
        checks++;
        if (n != 3 || cap_araddr !== 32'h4 || rd !== 32'hAAAA_5555) begin
            failures++; $display("FAIL b2b_r4 cyc=%0d addr=%h data=%h want=3/4/aaaa5555", n, cap_araddr, rd);
        end
        apb_xfer(1'b1, 32'h8, 32'h2222_2222, 4'h5, 3'b000, n, rd, err, tmo);
        checks++;
        if (n != 3 || cap_awaddr !== 32'h8 || cap_wdata !== 32'h2222_2222 || cap_wstrb !== 4'h5) begin
            failures++; $display("FAIL b2b_w8 cyc=%0d addr=%h data=%h strb=%h want=3/8/22222222/5", n, cap_awaddr, cap_wdata, cap_wstrb);
        end
        checks++;
        if (aw_hs - s_aw != 2 || w_hs - s_w != 2 || b_hs - s_b != 2 || ar_hs - s_ar != 1 || r_hs - s_r != 1) begin
            failures++; $display("FAIL b2b_counts aw=%0d w=%0d b=%0d ar=%0d r=%0d want=2/2/2/1/1", aw_hs - s_aw, w_hs - s_w, b_hs - s_b, ar_hs - s_ar, r_hs - s_r);
        end
    endtask

    task automatic test_reset_midflight();
        aw_delay = 20;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h50;
        PWDATA = 32'h3333_3333; PSTRB = 4'hF; PPROT = 3'b000;
        @(posedge ACLK); #1; PENABLE = 1'b1;
        @(posedge ACLK); #1;
        checks++; if (AWVALID !== 1'b1) begin failures++; $display("FAIL rst_pre_awvalid got=%b want=1", AWVALID); end
        ARESETn = 1'b0;
        #1;
        checks++;
        if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, PREADY, PSLVERR} !== 7'b0) begin
            failures++; $display("FAIL rst_mid_ctrl got=%b want=0", {AWVALID, WVALID, ARVALID, BREADY, RREADY, PREADY, PSLVERR});
        end
        checks++; if (PRDATA !== 32'h0) begin failures++; $display("FAIL rst_mid_prdata got=%h want=0", PRDATA); end
        PSEL = 1'b0; PENABLE = 1'b0; aw_delay = 0;
        @(posedge ACLK); #1; ARESETn = 1'b1;
        @(posedge ACLK); #1;
        snap();
        apb_xfer(1'b1, 32'h60, 32'h4444_4444, 4'hF, 3'b000, n, rd, err, tmo);
        checks++;
        if (n != 3 || tmo || err !== 1'b0 || b_hs - s_b != 1 || aw_hs - s_aw != 1) begin
            failures++; $display("FAIL rst_after_write cyc=%0d err=%b b=%0d aw=%0d want=3/0/1/1", n, err, b_hs - s_b, aw_hs - s_aw);
        end
        checks++;
        if (cap_awaddr !== 32'h60 || cap_wdata !== 32'h4444_4444) begin
            failures++; $display("FAIL rst_after_fields addr=%h data=%h want=60/44444444", cap_awaddr, cap_wdata);
        end
    endtask

    initial begin
        repeat (3) @(posedge ACLK);
        #1;
        test_reset();
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        test_write_basic();
        test_read_delayed();
        test_write_ordering();
        test_errors();
        test_back_to_back();
        test_reset_midflight();
        checks++; if (viol != 0) begin failures++; $display("FAIL protocol_monitor got=%0d want=0", viol); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
